// File: rtl/fb_scanout_pkg.sv
// Screen geometry and scanout state encoding. The GPU that draws into the
// framebuffer uses the same constants.
package fb_scanout_pkg;

  localparam logic [15:0] SCREEN_START = 16'h0100;
  localparam int          SCREEN_W     = 64;
  localparam int          SCREEN_H     = 32;
  localparam int          ROW_BYTES    = SCREEN_W / 8;
  localparam int          FB_BYTES     = ROW_BYTES * SCREEN_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    END  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/fb_byte_fetcher.sv
// Walks the framebuffer one byte at a time through the shared memory port and
// keeps a single prefetched byte ready for the pixel serialiser.
module fb_byte_fetcher
  import fb_scanout_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        active,
  input  logic        mem_busy,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_read_byte,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        take
);

  logic [8:0]  fetch_idx_reg;
  logic        mem_read_reg;
  logic        rd_wait_reg;
  logic [15:0] mem_addr_reg;
  logic [7:0]  nxt_reg;
  logic        nxt_valid_reg;
  logic        issue;

  // A read is in flight from the strobe cycle until the capture edge.
  assign issue = active && !nxt_valid_reg && !mem_read_reg && !rd_wait_reg &&
                 (fetch_idx_reg < 9'(FB_BYTES)) && !mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_idx_reg <= '0;
      mem_read_reg  <= 1'b0;
      rd_wait_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      nxt_reg       <= '0;
      nxt_valid_reg <= 1'b0;
    end else if (start) begin
      fetch_idx_reg <= '0;
      mem_read_reg  <= 1'b0;
      rd_wait_reg   <= 1'b0;
      nxt_valid_reg <= 1'b0;
    end else begin
      mem_read_reg <= issue;
      rd_wait_reg  <= mem_read_reg;
      if (issue) begin
        mem_addr_reg  <= SCREEN_START + {7'd0, fetch_idx_reg};
        fetch_idx_reg <= fetch_idx_reg + 9'd1;
      end
      // Capture happens only while the buffer is empty, so it never meets a take.
      if (rd_wait_reg) begin
        nxt_reg       <= mem_read_byte;
        nxt_valid_reg <= 1'b1;
      end else if (take) begin
        nxt_valid_reg <= 1'b0;
      end
    end
  end

  assign mem_read   = mem_read_reg;
  assign mem_addr   = mem_addr_reg;
  assign byte_valid = nxt_valid_reg;
  assign byte_data  = nxt_reg;

endmodule

// File: rtl/fb_scanout.sv
// Raster scanout of the 64x32 monochrome framebuffer as a valid/ready pixel
// stream, one frame after another while enabled.
module fb_scanout
  import fb_scanout_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mem_busy,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_read_byte,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [5:0]  pix_x,
  output logic [4:0]  pix_y,
  output logic        pix_first,
  output logic        pix_last,
  output logic        frame_done
);

  scan_state_e state_reg, state_next;
  logic [7:0]  cur_reg, cur_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        cur_valid_reg, cur_valid_next;
  logic [5:0]  x_reg, x_next;
  logic [4:0]  y_reg, y_next;
  logic        done_reg, done_next;

  logic        start;
  logic        take;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        accept;
  logic        at_last;

  fb_byte_fetcher u_fetch (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .active        (state_reg == RUN),
    .mem_busy      (mem_busy),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_read_byte (mem_read_byte),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .take          (take)
  );

  assign accept  = cur_valid_reg && pix_ready;
  assign at_last = (x_reg == 6'(SCREEN_W - 1)) && (y_reg == 5'(SCREEN_H - 1));

  always_comb begin
    state_next     = state_reg;
    cur_next       = cur_reg;
    cnt_next       = cnt_reg;
    cur_valid_next = cur_valid_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    done_next      = 1'b0;
    start          = 1'b0;
    take           = 1'b0;
    case (state_reg)
      IDLE, END: begin
        if (enable) begin
          state_next     = RUN;
          start          = 1'b1;
          x_next         = '0;
          y_next         = '0;
          cnt_next       = '0;
          cur_valid_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (accept) begin
          cur_next = {cur_reg[6:0], 1'b0};
          cnt_next = cnt_reg + 3'd1;
          x_next   = x_reg + 6'd1;
          if (x_reg == 6'(SCREEN_W - 1)) y_next = y_reg + 5'd1;
        end
        if (accept && at_last) begin
          done_next      = 1'b1;
          cur_valid_next = 1'b0;
          state_next     = END;
        end else if (!cur_valid_reg || (accept && cnt_reg == 3'd7)) begin
          // Refill in the same cycle the last bit leaves, so the stream has no gap.
          if (byte_valid) begin
            take           = 1'b1;
            cur_next       = byte_data;
            cnt_next       = '0;
            cur_valid_next = 1'b1;
          end else begin
            cur_valid_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_reg       <= '0;
      cnt_reg       <= '0;
      cur_valid_reg <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      cnt_reg       <= cnt_next;
      cur_valid_reg <= cur_valid_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      done_reg      <= done_next;
    end
  end

  assign pix_valid  = cur_valid_reg;
  assign pix_data   = cur_valid_reg & cur_reg[7];
  assign pix_x      = x_reg;
  assign pix_y      = y_reg;
  assign pix_first  = cur_valid_reg && (x_reg == 6'd0) && (y_reg == 5'd0);
  assign pix_last   = cur_valid_reg && at_last;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: framebuffer model on the memory port,
// negedge monitor of reads and accepted pixels, per-frame checks.
module tb_fb_scanout;
  import fb_scanout_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mem_busy = 1'b0;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [7:0]  mem_read_byte;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_data;
  logic [5:0]  pix_x;
  logic [4:0]  pix_y;
  logic        pix_first;
  logic        pix_last;
  logic        frame_done;

  logic [7:0]  fb [0:255];

  fb_scanout dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mem_busy      (mem_busy),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_read_byte (mem_read_byte),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_first     (pix_first),
    .pix_last      (pix_last),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  assign mem_read_byte = (mem_addr[15:8] == 8'h01) ? fb[mem_addr[7:0]] : 8'h00;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  int   cyc = 0, pix_cnt = 0, rd_cnt = 0, busy_viol = 0, addr_err = 0, order_err = 0;
  int   bubbles = 0, first_cnt = 0, first_idx = -1, last_cnt = 0, last_idx = -1;
  int   done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  logic busy_prev = 1'b0;
  logic pix_got [0:2047];

  task automatic clear_mon();
    pix_cnt = 0; rd_cnt = 0; busy_viol = 0; addr_err = 0; order_err = 0;
    bubbles = 0; first_cnt = 0; first_idx = -1; last_cnt = 0; last_idx = -1;
    done_cnt = 0; done_cyc = 0; last_acc_cyc = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mem_read) begin
      if (busy_prev) busy_viol++;
      if (mem_addr !== 16'h0100 + rd_cnt[15:0]) addr_err++;
      rd_cnt++;
    end
    busy_prev = mem_busy;
    if (pix_cnt > 0 && pix_cnt < 2048 && !pix_valid) bubbles++;
    if (pix_valid && pix_ready && pix_cnt < 2048) begin
      if (pix_x != 6'(pix_cnt % 64) || pix_y != 5'(pix_cnt / 64)) order_err++;
      pix_got[pix_cnt] = pix_data;
      if (pix_first) begin first_cnt++; first_idx = pix_cnt; end
      if (pix_last)  begin last_cnt++;  last_idx  = pix_cnt; end
      last_acc_cyc = cyc;
      pix_cnt++;
    end
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
  end

  function automatic int data_errs();
    int n = 0;
    logic [7:0] b;
    for (int i = 0; i < 2048; i++) begin
      b = fb[(i / 64) * 8 + (i % 64) / 8];
      if (pix_got[i] !== b[7 - (i % 8)]) n++;
    end
    return n;
  endfunction

  function automatic int lit_count();
    int n = 0;
    for (int i = 0; i < 2048; i++) if (pix_got[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin tick(); n++; end
    if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_pix(input string tag, input int x, input int y, input int bound);
    int n = 0;
    while (!(pix_valid && pix_x == 6'(x) && pix_y == 5'(y)) && n < bound) begin tick(); n++; end
    if (n >= bound) check({tag, "_pix_timeout"}, 0, 1);
  endtask

  task automatic frame_checks(input string tag, input bit chk_bubbles);
    check({tag, "_pix_cnt"},   pix_cnt, 2048);
    check({tag, "_data"},      data_errs(), 0);
    check({tag, "_order"},     order_err, 0);
    check({tag, "_first_cnt"}, first_cnt, 1);
    check({tag, "_first_idx"}, first_idx, 0);
    check({tag, "_last_cnt"},  last_cnt, 1);
    check({tag, "_last_idx"},  last_idx, 2047);
    check({tag, "_done_cnt"},  done_cnt, 1);
    check({tag, "_done_lag"},  done_cyc - last_acc_cyc, 1);
    check({tag, "_reads"},     rd_cnt, 256);
    check({tag, "_addr"},      addr_err, 0);
    check({tag, "_busy_viol"}, busy_viol, 0);
    if (chk_bubbles) check({tag, "_bubbles"}, bubbles, 0);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    logic [7:0] hold_x, hold_y;
    logic       hold_d;
    int         stall_chg, n;

    // Reset held with enable high.
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    fb[0] = 8'h80;
    rst_n = 1'b0; enable = 1'b1;
    repeat (3) tick();
    check("rst_mem_read", mem_read, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_xy", {pix_x, pix_y}, 0);
    clear_mon();
    rst_n = 1'b1;
    n = 0;
    while (!mem_read && n < 20) begin tick(); n++; end
    check("first_read_seen", mem_read, 1);
    check("first_read_addr", mem_addr, 16'h0100);
    enable = 1'b0;
    wait_done("f1", 4000);
    frame_checks("f1", 1);
    check("f1_pix00", pix_got[0], 1);
    check("f1_lit", lit_count(), 1);
    repeat (10) tick();
    check("f1_idle_reads", rd_cnt, 256);
    check("f1_idle_valid", pix_valid, 0);

    // Only the bottom-right pixel lit.
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    fb[255] = 8'h01;
    clear_mon();
    pulse_enable();
    wait_done("f2", 4000);
    frame_checks("f2", 1);
    check("f2_pix2047", pix_got[2047], 1);
    check("f2_lit", lit_count(), 1);
    repeat (3) tick();

    // Five-cycle sink stall at (13,4).
    for (int i = 0; i < 256; i++) fb[i] = 8'(i * 37 + 11);
    clear_mon();
    pulse_enable();
    wait_pix("f3", 13, 4, 1000);
    hold_d = pix_data; hold_x = 8'(pix_x); hold_y = 8'(pix_y);
    pix_ready = 1'b0;
    stall_chg = 0;
    repeat (5) begin
      tick();
      if (!pix_valid || pix_data !== hold_d || 8'(pix_x) != hold_x || 8'(pix_y) != hold_y)
        stall_chg++;
    end
    check("f3_stall_stable", stall_chg, 0);
    pix_ready = 1'b1;
    tick();
    check("f3_resume_xy", {pix_x, pix_y}, {6'd14, 5'd4});
    wait_done("f3", 4000);
    frame_checks("f3", 1);
    repeat (3) tick();

    // Memory port busy at frame start, then toggling.
    for (int i = 0; i < 256; i++) fb[i] = 8'(i) ^ 8'hA5;
    clear_mon();
    mem_busy = 1'b1;
    pulse_enable();
    repeat (19) tick();
    check("f4_busy_no_read", rd_cnt, 0);
    mem_busy = 1'b0;
    tick();
    check("f4_read_after_busy", mem_read, 1);
    check("f4_read_addr", mem_addr, 16'h0100);
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      mem_busy = ~mem_busy;
      tick();
      n++;
    end
    mem_busy = 1'b0;
    if (done_cnt == 0) check("f4_done_timeout", 0, 1);
    frame_checks("f4", 0);
    repeat (3) tick();

    // enable dropped mid-frame: frame still completes, then idles.
    for (int i = 0; i < 256; i++) fb[i] = 8'(i * 13) ^ 8'h3C;
    clear_mon();
    enable = 1'b1;
    wait_pix("f5", 10, 10, 2000);
    enable = 1'b0;
    wait_done("f5", 4000);
    frame_checks("f5", 1);
    repeat (10) tick();
    check("f5_idle_reads", rd_cnt, 256);
    check("f5_idle_valid", pix_valid, 0);

    // Asynchronous reset at (5,5).
    clear_mon();
    pulse_enable();
    wait_pix("f6", 5, 5, 2000);
    rst_n = 1'b0;
    #1;
    check("f6_rst_valid", pix_valid, 0);
    check("f6_rst_read", mem_read, 0);
    check("f6_rst_xy", {pix_x, pix_y}, 0);
    check("f6_rst_data", pix_data, 0);
    tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (10) tick();
    check("f6_post_reads", rd_cnt, 0);
    check("f6_post_pix", pix_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
